// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encodings,
// opcode constants and the opcode classifier.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_LD   = 6'b100000;
  localparam logic [5:0] OP_ST   = 6'b100001;
  localparam logic [5:0] OP_ADDI = 6'b100010;
  localparam logic [5:0] OP_BEQ  = 6'b100100;
  localparam logic [5:0] OP_JMP  = 6'b100101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_LD,
    C_ST,
    C_ADDI,
    C_BEQ,
    C_JMP,
    C_HALT,
    C_ILLEGAL
  } op_class_t;

  // Any opcode with bit 5 clear is an R-type ALU operation.
  function automatic op_class_t decode_op(input logic [5:0] op);
    op_class_t cls;
    if (!op[5]) begin
      cls = C_RTYPE;
    end else begin
      case (op)
        OP_LD:   cls = C_LD;
        OP_ST:   cls = C_ST;
        OP_ADDI: cls = C_ADDI;
        OP_BEQ:  cls = C_BEQ;
        OP_JMP:  cls = C_JMP;
        OP_HALT: cls = C_HALT;
        default: cls = C_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge bus between the controller (master) and memory (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB/HALT) with Mealy memory handshakes.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 zero,
  multicycle_ctrl_if.master    bus,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 alu_src_imm,
  output logic                 rf_we,
  output logic                 wb_sel,
  output logic                 halted,
  output logic                 illegal,
  output logic [2:0]           state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]          cyc_cnt,
  output logic [31:0]          ret_cnt
`endif
);

  state_t    r_state;
  state_t    w_next;
  logic      r_illegal;
  logic      w_set_illegal;
  op_class_t w_op;

  logic w_mem_req, w_mem_we, w_addr_sel;
  logic w_ir_we, w_pc_we, w_pc_sel, w_alu_src_imm, w_rf_we, w_wb_sel, w_halted;

  assign w_op = decode_op(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IF;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_addr_sel    = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_sel      = 1'b0;
    w_alu_src_imm = 1'b0;
    w_rf_we       = 1'b0;
    w_wb_sel      = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      S_IF: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_ID;
        end
      end
      S_ID: begin
        case (w_op)
          C_HALT:    w_next = S_HALT;
          C_ILLEGAL: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
          default:   w_next = S_EX;
        endcase
      end
      S_EX: begin
        case (w_op)
          C_RTYPE: w_next = S_WB;
          C_ADDI: begin
            w_alu_src_imm = 1'b1;
            w_next        = S_WB;
          end
          C_LD, C_ST: begin
            w_alu_src_imm = 1'b1;
            w_next        = S_MEM;
          end
          C_BEQ: begin
            w_pc_we  = zero;
            w_pc_sel = 1'b1;
            w_next   = S_IF;
          end
          C_JMP: begin
            w_pc_we  = 1'b1;
            w_pc_sel = 1'b1;
            w_next   = S_IF;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (w_op == C_ST);
        if (bus.mem_ack) w_next = (w_op == C_LD) ? S_WB : S_IF;
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_wb_sel = (w_op == C_LD);
        w_next   = S_IF;
      end
      S_HALT: w_halted = 1'b1;
      default: w_next = S_IF;
    endcase
  end

  // Reset masks every output except the raw state so nothing strobes mid-reset.
  assign bus.mem_req  = w_mem_req     & ~rst;
  assign bus.mem_we   = w_mem_we      & ~rst;
  assign bus.addr_sel = w_addr_sel    & ~rst;
  assign ir_we        = w_ir_we       & ~rst;
  assign pc_we        = w_pc_we       & ~rst;
  assign pc_sel       = w_pc_sel      & ~rst;
  assign alu_src_imm  = w_alu_src_imm & ~rst;
  assign rf_we        = w_rf_we       & ~rst;
  assign wb_sel       = w_wb_sel      & ~rst;
  assign halted       = w_halted      & ~rst;
  assign illegal      = r_illegal     & ~rst;
  assign state        = r_state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_ret_cnt;
  logic        w_retire;

  assign w_retire = (w_next == S_IF) &&
                    ((r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_retire)          r_ret_cnt <= r_ret_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are
// queued with the stimulus and compared on the falling edge.
module tb_multicycle_ctrl;

  // Vector layout: {state[2:0], mem_req, mem_we, addr_sel | ir_we, pc_we, pc_sel, alu_src_imm | rf_we, wb_sel, halted, illegal}
  localparam logic [13:0] E_RST_IF   = {3'd0, 11'b000_0000_0000};
  localparam logic [13:0] E_IF_WAIT  = {3'd0, 11'b100_0000_0000};
  localparam logic [13:0] E_IF_ACK   = {3'd0, 11'b100_1100_0000};
  localparam logic [13:0] E_ID       = {3'd1, 11'b000_0000_0000};
  localparam logic [13:0] E_EX_R     = {3'd2, 11'b000_0000_0000};
  localparam logic [13:0] E_EX_IMM   = {3'd2, 11'b000_0001_0000};
  localparam logic [13:0] E_EX_BR0   = {3'd2, 11'b000_0010_0000};
  localparam logic [13:0] E_EX_BR1   = {3'd2, 11'b000_0110_0000};
  localparam logic [13:0] E_MEM_LD   = {3'd3, 11'b101_0000_0000};
  localparam logic [13:0] E_MEM_ST   = {3'd3, 11'b111_0000_0000};
  localparam logic [13:0] E_RST_MEM  = {3'd3, 11'b000_0000_0000};
  localparam logic [13:0] E_WB_ALU   = {3'd4, 11'b000_0000_1000};
  localparam logic [13:0] E_WB_LD    = {3'd4, 11'b000_0000_1100};
  localparam logic [13:0] E_HALT_ILL = {3'd5, 11'b000_0000_0011};
  localparam logic [13:0] E_HALT     = {3'd5, 11'b000_0000_0010};
  localparam logic [13:0] E_RST_HALT = {3'd5, 11'b000_0000_0000};

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LD   = 6'b100000;
  localparam logic [5:0] T_ST   = 6'b100001;
  localparam logic [5:0] T_ADDI = 6'b100010;
  localparam logic [5:0] T_BEQ  = 6'b100100;
  localparam logic [5:0] T_JMP  = 6'b100101;
  localparam logic [5:0] T_HALT = 6'b111111;
  localparam logic [5:0] T_BAD  = 6'b110000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_we, pc_we, pc_sel, alu_src_imm, rf_we, wb_sel, halted, illegal;
  logic [2:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .bus         (bus_if),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .alu_src_imm (alu_src_imm),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .illegal     (illegal),
    .state       (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .ret_cnt     (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [13:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  wire [13:0] obs = {state, bus_if.mem_req, bus_if.mem_we, bus_if.addr_sel,
                     ir_we, pc_we, pc_sel, alu_src_imm, rf_we, wb_sel, halted, illegal};

  always @(negedge clk) begin
    if (exp_q.size() > 0) check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
  end

  task automatic step(input string tag, input logic [5:0] op, input logic z,
                      input logic ack, input logic r, input logic [13:0] exp);
    @(posedge clk);
    #1;
    opcode         = op;
    zero           = z;
    bus_if.mem_ack = ack;
    rst            = r;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; bus_if.mem_ack = 1'b0;
    @(posedge clk);
    step("reset",    T_R, 1'b0, 1'b1, 1'b1, E_RST_IF);

    step("r.if",     T_R, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("r.id",     T_R, 1'b0, 1'b1, 1'b0, E_ID);
    step("r.ex",     T_R, 1'b0, 1'b1, 1'b0, E_EX_R);
    step("r.wb",     T_R, 1'b0, 1'b1, 1'b0, E_WB_ALU);

    step("addi.ifw", T_ADDI, 1'b0, 1'b0, 1'b0, E_IF_WAIT);
    step("addi.if",  T_ADDI, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("addi.id",  T_ADDI, 1'b0, 1'b1, 1'b0, E_ID);
    step("addi.ex",  T_ADDI, 1'b0, 1'b1, 1'b0, E_EX_IMM);
    step("addi.wb",  T_ADDI, 1'b0, 1'b1, 1'b0, E_WB_ALU);

    step("ld.if",    T_LD, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("ld.id",    T_LD, 1'b0, 1'b1, 1'b0, E_ID);
    step("ld.ex",    T_LD, 1'b0, 1'b1, 1'b0, E_EX_IMM);
    step("ld.mem0",  T_LD, 1'b0, 1'b0, 1'b0, E_MEM_LD);
    step("ld.mem1",  T_LD, 1'b0, 1'b0, 1'b0, E_MEM_LD);
    step("ld.mem2",  T_LD, 1'b0, 1'b1, 1'b0, E_MEM_LD);
    step("ld.wb",    T_LD, 1'b0, 1'b1, 1'b0, E_WB_LD);

    step("st.if",    T_ST, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("st.id",    T_ST, 1'b0, 1'b1, 1'b0, E_ID);
    step("st.ex",    T_ST, 1'b0, 1'b1, 1'b0, E_EX_IMM);
    step("st.mem",   T_ST, 1'b0, 1'b1, 1'b0, E_MEM_ST);

    step("beq0.if",  T_BEQ, 1'b1, 1'b1, 1'b0, E_IF_ACK);
    step("beq0.id",  T_BEQ, 1'b1, 1'b1, 1'b0, E_ID);
    step("beq0.ex",  T_BEQ, 1'b0, 1'b1, 1'b0, E_EX_BR0);
    step("beq1.if",  T_BEQ, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("beq1.id",  T_BEQ, 1'b0, 1'b1, 1'b0, E_ID);
    step("beq1.ex",  T_BEQ, 1'b1, 1'b1, 1'b0, E_EX_BR1);

    step("jmp.if",   T_JMP, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("jmp.id",   T_JMP, 1'b0, 1'b1, 1'b0, E_ID);
    step("jmp.ex",   T_JMP, 1'b0, 1'b1, 1'b0, E_EX_BR1);

    step("strst.if",  T_ST, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("strst.id",  T_ST, 1'b0, 1'b1, 1'b0, E_ID);
    step("strst.ex",  T_ST, 1'b0, 1'b1, 1'b0, E_EX_IMM);
    step("strst.mem", T_ST, 1'b0, 1'b1, 1'b1, E_RST_MEM);
    step("strst.post", T_ST, 1'b0, 1'b0, 1'b0, E_IF_WAIT);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("cyc_after_rst", cyc_cnt, 32'd0);
    check("ret_after_rst", ret_cnt, 32'd0);
`endif

    step("r2.if",    T_R, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("r2.id",    T_R, 1'b0, 1'b0, 1'b0, E_ID);
    step("r2.ex",    T_R, 1'b0, 1'b0, 1'b0, E_EX_R);
    step("r2.wb",    T_R, 1'b0, 1'b0, 1'b0, E_WB_ALU);

    step("bad.if",   T_BAD, 1'b0, 1'b1, 1'b0, E_IF_ACK);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("cyc_r2", cyc_cnt, 32'd5);
    check("ret_r2", ret_cnt, 32'd1);
`endif
    step("bad.id",   T_BAD, 1'b0, 1'b1, 1'b0, E_ID);
    for (int i = 0; i < 20; i++) step("bad.halt", T_BAD, 1'b0, 1'b1, 1'b0, E_HALT_ILL);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("cyc_frozen", cyc_cnt, 32'd7);
    check("ret_frozen", ret_cnt, 32'd1);
`endif
    step("bad.rst",  T_BAD, 1'b0, 1'b1, 1'b1, E_RST_HALT);
    step("bad.post", T_R,   1'b0, 1'b0, 1'b0, E_IF_WAIT);

    step("halt.if",  T_HALT, 1'b0, 1'b1, 1'b0, E_IF_ACK);
    step("halt.id",  T_HALT, 1'b0, 1'b1, 1'b0, E_ID);
    for (int i = 0; i < 3; i++) step("halt.halt", T_HALT, 1'b0, 1'b1, 1'b0, E_HALT);
    step("halt.rst",  T_HALT, 1'b0, 1'b1, 1'b1, E_RST_HALT);
    step("halt.post", T_R,    1'b0, 1'b0, 1'b0, E_IF_WAIT);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
